// File: rtl/ifu_fq_if.sv
// ifu_fq_if: bundles the three handshakes around the fetch unit.
//   I-mem request : im_req_addr / im_req_valid / im_req_ready
//   I-mem response: im_resp_rdata / im_resp_valid (in order, never stalled)
//   Redirect      : if_redirect_valid / if_redirect_pc
//   Decoder       : if_dec_pc / if_dec_instr / if_dec_valid / if_dec_ready
// The master modport is the fetch unit itself; slave is its environment
// (I-mem, branch unit and decoder seen from the other side).
interface ifu_fq_if;
    logic [63:0] im_req_addr;
    logic        im_req_valid;
    logic        im_req_ready;
    logic [63:0] im_resp_rdata;
    logic        im_resp_valid;
    logic        if_redirect_valid;
    logic [63:0] if_redirect_pc;
    logic [63:0] if_dec_pc;
    logic [31:0] if_dec_instr;
    logic        if_dec_valid;
    logic        if_dec_ready;

    modport master (
        output im_req_addr, im_req_valid,
        input  im_req_ready,
        input  im_resp_rdata, im_resp_valid,
        input  if_redirect_valid, if_redirect_pc,
        output if_dec_pc, if_dec_instr, if_dec_valid,
        input  if_dec_ready
    );

    modport slave (
        input  im_req_addr, im_req_valid,
        output im_req_ready,
        output im_resp_rdata, im_resp_valid,
        output if_redirect_valid, if_redirect_pc,
        input  if_dec_pc, if_dec_instr, if_dec_valid,
        output if_dec_ready
    );
endinterface

// File: rtl/ifu_fq.sv
// ifu_fq: instruction fetch unit with a decoupled FWFT fetch queue.
// Issues sequential 4-byte-stepped fetches (I-mem returns the aligned
// doubleword, the instruction is picked by pc[2]), keeps up to
// MAX_OUTSTANDING requests in flight and buffers {pc, instr} pairs for the
// decoder. A redirect flushes the queue and marks all in-flight fetches as
// stale so their responses are discarded when they return.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   bus    - ifu_fq_if.master: I-mem request/response, redirect, decoder
module ifu_fq #(
    parameter logic [63:0] RESET_VECTOR    = 64'h0000_0000_1000_0000,
    parameter int          FQ_DEPTH        = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    ifu_fq_if.master  bus
);
    localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [63:0]   fetch_pc_reg, fetch_pc_next;
    logic [63:0]   resp_pc_reg, resp_pc_next;
    logic [OW-1:0] outstanding_reg, outstanding_next;
    logic [OW-1:0] drop_cnt_reg, drop_cnt_next;
    logic [CW-1:0] count_reg, count_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;

    logic [63:0] pc_mem    [FQ_DEPTH];
    logic [31:0] instr_mem [FQ_DEPTH];

    logic        redirect;
    logic        issue_ok;
    logic        req_fire;
    logic        push;
    logic        pop;
    logic [31:0] occupancy;
    logic [31:0] resp_instr;

    assign redirect = bus.if_redirect_valid;

    // Slots already promised: queued entries plus live (non-stale) fetches.
    // Issuing only while this is below FQ_DEPTH means every live response
    // finds a free slot, so responses never need to be back-pressured.
    assign occupancy = 32'(count_reg) + 32'(outstanding_reg) - 32'(drop_cnt_reg);

    assign issue_ok = rst_n && !redirect
                   && (32'(outstanding_reg) < 32'(MAX_OUTSTANDING))
                   && (occupancy < 32'(FQ_DEPTH));
    assign req_fire = issue_ok && bus.im_req_ready;

    assign push = bus.im_resp_valid && (drop_cnt_reg == '0) && !redirect;
    assign pop  = bus.if_dec_valid && bus.if_dec_ready;

    assign resp_instr = resp_pc_reg[2] ? bus.im_resp_rdata[63:32]
                                       : bus.im_resp_rdata[31:0];

    assign bus.im_req_addr  = fetch_pc_reg;
    assign bus.im_req_valid = issue_ok;
    assign bus.if_dec_valid = (count_reg != '0) && !redirect;
    assign bus.if_dec_pc    = pc_mem[rd_ptr_reg];
    assign bus.if_dec_instr = instr_mem[rd_ptr_reg];

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        resp_pc_next     = resp_pc_reg;
        outstanding_next = outstanding_reg;
        drop_cnt_next    = drop_cnt_reg;
        count_next       = count_reg;
        rd_ptr_next      = rd_ptr_reg;
        wr_ptr_next      = wr_ptr_reg;

        if (redirect) begin
            // Everything still in flight becomes stale; a response landing
            // in this very cycle is consumed (and discarded) right now.
            fetch_pc_next    = bus.if_redirect_pc;
            resp_pc_next     = bus.if_redirect_pc;
            outstanding_next = outstanding_reg - (bus.im_resp_valid ? OW'(1) : OW'(0));
            drop_cnt_next    = outstanding_reg - (bus.im_resp_valid ? OW'(1) : OW'(0));
            count_next       = '0;
            rd_ptr_next      = '0;
            wr_ptr_next      = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + 64'd4;
            end
            case ({req_fire, bus.im_resp_valid})
                2'b10:   outstanding_next = outstanding_reg + OW'(1);
                2'b01:   outstanding_next = outstanding_reg - OW'(1);
                default: outstanding_next = outstanding_reg;
            endcase
            if (bus.im_resp_valid && (drop_cnt_reg != '0)) begin
                drop_cnt_next = drop_cnt_reg - OW'(1);
            end
            if (push) begin
                resp_pc_next = resp_pc_reg + 64'd4;
                wr_ptr_next  = wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg    <= RESET_VECTOR;
            resp_pc_reg     <= RESET_VECTOR;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            resp_pc_reg     <= resp_pc_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
            count_reg       <= count_next;
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
        end
    end

    // Queue payload needs no reset: an entry is only visible once count
    // says it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]    <= resp_pc_reg;
            instr_mem[wr_ptr_reg] <= resp_instr;
        end
    end
endmodule
